// File: rtl/hash160_digest_tx.sv
`default_nettype none
// hash160_digest_tx: captures the Hash160 digest on a rising i_valid and streams it MSB first
// over a valid/ready byte interface. Define HASH160_TX_HEX_EN for lowercase ASCII-hex output.
module hash160_digest_tx #(
    parameter int DIGEST_W = 160
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [DIGEST_W-1:0] i_digest,
    output logic [7:0]          o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_last,
    output logic                o_busy,
    output logic                o_drop
);

`ifdef HASH160_TX_HEX_EN
    localparam int SYM_W = 4;
`else
    localparam int SYM_W = 8;
`endif
    localparam int         NBEATS    = DIGEST_W / SYM_W;
    localparam logic [5:0] LAST_BEAT = 6'(NBEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [5:0]          cnt;
    logic [DIGEST_W-1:0] shreg;
    logic                valid_d;
    logic                drop;

    logic                capture;
    logic                handshake;
    logic                last_beat;
    logic [SYM_W-1:0]    head;
    logic [7:0]          sym_byte;

    assign capture   = i_valid & ~valid_d;
    assign last_beat = (cnt == LAST_BEAT);
    assign handshake = (state == SEND) & i_ready;
    assign head      = shreg[DIGEST_W-1 -: SYM_W];

`ifdef HASH160_TX_HEX_EN
    // 0-9 map to '0'-'9', 10-15 map to 'a'-'f' (0x61 - 10 = 0x57)
    always_comb begin
        if (head < 4'd10) sym_byte = 8'h30 + {4'h0, head};
        else              sym_byte = 8'h57 + {4'h0, head};
    end
`else
    assign sym_byte = head;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_valid   = 1'b0;
        o_busy    = 1'b0;
        o_last    = 1'b0;
        o_data    = 8'h00;
        case (state)
            IDLE: begin
                if (capture) state_nxt = SEND;
            end
            SEND: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                o_last  = last_beat;
                o_data  = sym_byte;
                if (handshake && last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A rising edge seen while a frame is in flight is refused, including on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_d <= 1'b0;
            drop    <= 1'b0;
            cnt     <= 6'd0;
            shreg   <= '0;
        end else begin
            valid_d <= i_valid;
            drop    <= capture & (state == SEND);
            if (state == IDLE && capture) begin
                shreg <= i_digest;
                cnt   <= 6'd0;
            end else if (handshake) begin
                shreg <= shreg << SYM_W;
                cnt   <= cnt + 6'd1;
            end
        end
    end

    assign o_drop = drop;

endmodule
`default_nettype wire

// File: tb/tb_hash160_digest_tx.sv
`default_nettype none
// tb_hash160_digest_tx: directed and randomized stimulus checked against a queue-based model.
module tb_hash160_digest_tx;

    localparam int DW = 160;
`ifdef HASH160_TX_HEX_EN
    localparam int NB = DW / 4;
`else
    localparam int NB = DW / 8;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_digest = '0;
    logic          i_ready = 1'b0;
    logic [7:0]    o_data;
    logic          o_valid;
    logic          o_last;
    logic          o_busy;
    logic          o_drop;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0] m_q[$];
    logic       m_prev = 1'b0;
    logic       m_drop = 1'b0;
    int         m_frames = 0;
    int         m_hs = 0;
    int         m_drops = 0;
    int         m_bad_last = 0;

    always #5 clk = ~clk;

    hash160_digest_tx #(.DIGEST_W(DW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_digest(i_digest),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_last(o_last), .o_busy(o_busy), .o_drop(o_drop)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] beat(input logic [DW-1:0] d, input int k);
        logic [DW-1:0] s;
        logic [7:0]    b;
`ifdef HASH160_TX_HEX_EN
        s = d >> (4 * (NB - 1 - k));
        b = {4'h0, s[3:0]};
        return (b < 8'd10) ? (8'h30 + b) : (8'h61 + b - 8'd10);
`else
        s = d >> (8 * (NB - 1 - k));
        b = s[7:0];
        return b;
`endif
    endfunction

    // Drive inputs for one cycle (starting just after a falling edge), check, advance the model.
    task automatic cycle(input logic v, input logic r);
        logic busy;
        logic rise;
        i_valid = v;
        i_ready = r;
        #1;
        busy = (m_q.size() != 0);
        check_eq("valid", o_valid, busy);
        check_eq("busy", o_busy, busy);
        check_eq("drop", o_drop, m_drop);
        check_eq("data", o_data, busy ? m_q[0] : 8'h00);
        check_eq("last", o_last, busy && m_q.size() == 1);
        rise   = v && !m_prev;
        m_drop = rise && busy;
        if (m_drop) m_drops++;
        if (busy && r) begin
            m_hs++;
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_frames++;
        end else if (!busy && rise) begin
            for (int k = 0; k < NB; k++) m_q.push_back(beat(i_digest, k));
        end
        m_prev = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_valid", o_valid, 1'b0);
        check_eq("rst_data", o_data, 8'h00);
        check_eq("rst_last", o_last, 1'b0);
        check_eq("rst_busy", o_busy, 1'b0);
        check_eq("rst_drop", o_drop, 1'b0);
        m_q.delete();
        m_prev = 1'b0;
        m_drop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int f0, h0, d0;
        logic [DW-1:0] dig;
        dig = 160'h0123456789abcdef0011223344556677_8899aabb;
        @(negedge clk);
        do_reset();

        // directed frame, ready held high
        i_digest = dig;
        f0 = m_frames; h0 = m_hs;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < NB + 4; i++) cycle(1'b0, 1'b1);
        check_eq("frame1_count", m_frames - f0, 1);
        check_eq("frame1_hs", m_hs - h0, NB);

        // backpressure 1,0,0,1 repeating
        f0 = m_frames; h0 = m_hs;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 4 * NB + 8; i++) cycle(1'b1, (i % 4 == 0) || (i % 4 == 3));
        check_eq("bp_frames", m_frames - f0, 1);
        check_eq("bp_hs", m_hs - h0, NB);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

        // valid held high for 200 cycles: one frame, no drops
        f0 = m_frames; d0 = m_drops;
        i_digest = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1);
        check_eq("hold_frames", m_frames - f0, 1);
        check_eq("hold_drops", m_drops - d0, 0);
        cycle(1'b0, 1'b1);

        // refused rising edge at beat 5
        f0 = m_frames; d0 = m_drops;
        i_digest = dig;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
        i_digest = ~dig;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < NB + 10; i++) cycle(1'b1, 1'b1);
        check_eq("refuse_drops", m_drops - d0, 1);
        check_eq("refuse_frames", m_frames - f0, 1);
        cycle(1'b0, 1'b1);

        // reset at beat 10 with valid still high, then fresh frame
        i_digest = dig;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
        i_valid = 1'b1;
        do_reset();
        f0 = m_frames; h0 = m_hs;
        for (int i = 0; i < NB + 5; i++) cycle(1'b1, 1'b1);
        check_eq("post_rst_frames", m_frames - f0, 1);
        check_eq("post_rst_hs", m_hs - h0, NB);
        cycle(1'b0, 1'b1);

        // boundary digest: all-zero except low byte ff
        i_digest = 160'hff;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < NB + 3; i++) cycle(1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                i_digest = {$urandom, $urandom, $urandom, $urandom, $urandom};
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
